pattern_sweeper: RTL and testbench

PATTERN_SWEEPER -- requirements
Module: pattern_sweeper

---
 rtl/sweep_pkg.sv | 16 +
 rtl/sweep_fsm.sv | 41 ++++
 rtl/pattern_sweeper.sv | 92 +++++++++
 tb/tb_pattern_sweeper.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared definitions for the pattern sweeper: FSM state encoding and
// the binary-to-Gray conversion used to order the stimulus vectors.
package sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } sweep_state_e;

  // Operates on the widest legal vector; callers slice down to WIDTH.
  function automatic logic [7:0] gray_code(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sweep_fsm.sv
// Sweep control state machine: IDLE -> DRIVE -> DONE -> IDLE.
// busy/done decode directly from the state register.
module sweep_fsm
  import sweep_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         last_step,
  output sweep_state_e state,
  output logic         busy,
  output logic         done
);

  sweep_state_e state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRIVE;
      S_DRIVE: begin
        busy = 1'b1;
        if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/pattern_sweeper.sv
// Exhaustive input sweeper: drives every WIDTH-bit vector for DWELL cycles,
// compares the DUT response against exp_table and tallies mismatches.
module pattern_sweeper
  import sweep_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DWELL = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [2**WIDTH-1:0]   exp_table,
  input  logic                  dut_out,
  output logic [WIDTH-1:0]      stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [WIDTH:0]        err_count,
  output logic [WIDTH-1:0]      first_fail
);

  localparam int              NVEC     = 1 << WIDTH;
  localparam logic [WIDTH:0]  ERR_MAX  = NVEC[WIDTH:0];
  localparam logic [WIDTH-1:0] IDX_LAST = '1;
  localparam logic [7:0]      DW_LAST  = 8'(DWELL - 1);

  sweep_state_e     state;
  logic [WIDTH-1:0] idx, idx_nxt, vec_nxt;
  logic [7:0]       dwell, gray8;
  logic             mode_q;
  logic             accept, step, last_step, mismatch;

  always_comb begin
    accept    = (state == S_IDLE) && start;
    step      = (state == S_DRIVE) && (dwell == DW_LAST);
    last_step = step && (idx == IDX_LAST);
    mismatch  = dut_out != exp_table[stim];
    idx_nxt   = idx + 1'b1;
    gray8     = gray_code(8'(idx_nxt));
    vec_nxt   = mode_q ? gray8[WIDTH-1:0] : idx_nxt;
  end

  sweep_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_step (last_step),
    .state     (state),
    .busy      (busy),
    .done      (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      dwell      <= '0;
      mode_q     <= 1'b0;
      stim       <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (accept) begin
      // Vector 0 is the same in binary and Gray order.
      idx        <= '0;
      dwell      <= '0;
      mode_q     <= mode;
      stim       <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (state == S_DRIVE) begin
      if (step) begin
        dwell <= '0;
        if (mismatch) begin
          if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
          if (err_count == '0)      first_fail <= stim;
        end
        // On the final vector idx/stim freeze so results hold in IDLE.
        if (idx != IDX_LAST) begin
          idx  <= idx_nxt;
          stim <= vec_nxt;
        end
      end else begin
        dwell <= dwell + 1'b1;
      end
    end else if (state == S_DONE) begin
      pass <= (err_count == '0);
    end
  end

endmodule

// File: tb/tb_pattern_sweeper.sv
// Directed bench: 3-bit/4-cycle sweeper against an XOR3 model, plus a
// 1-bit/1-cycle instance for the minimal-dwell corner.
module tb_pattern_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, mode_a, stuck;
  logic [7:0] exp_a;
  logic       dut_out_a;
  logic [2:0] stim_a, ff_a;
  logic [3:0] err_a;
  logic       busy_a, done_a, pass_a;

  logic       start_b;
  logic [1:0] exp_b;
  logic       stim_b, ff_b, busy_b, done_b, pass_b;
  logic [1:0] err_b;

  int n_assert = 0;
  int n_fail   = 0;

  int bin_seq  [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int gray_seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  always #5 clk = ~clk;

  assign dut_out_a = stuck ? 1'b0 : ^stim_a;

  pattern_sweeper #(.WIDTH(3), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .exp_table(exp_a),
    .dut_out(dut_out_a), .stim(stim_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail(ff_a)
  );

  pattern_sweeper #(.WIDTH(1), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(1'b0), .exp_table(exp_b),
    .dut_out(stim_b), .stim(stim_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail(ff_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full sweep on dut_a, checked every cycle. Cycle c is the falling edge
  // after rising edge (accept + c - 1); done is due at c = 33.
  task automatic run_a(input bit gray, input bit stk, input bit pulses);
    int exp_v;
    @(negedge clk);
    mode_a = gray; stuck = stk; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c > 1) @(negedge clk);
      if (pulses && (c == 3 || c == 10)) begin
        start_a = 1'b1;
        mode_a  = ~mode_a;
      end else if (pulses && (c == 4 || c == 11)) begin
        start_a = 1'b0;
      end
      exp_v = gray ? gray_seq[(c <= 32) ? (c - 1) / 4 : 7]
                   : bin_seq [(c <= 32) ? (c - 1) / 4 : 7];
      chk("stim", stim_a, exp_v);
      chk("done", done_a, c == 33);
      chk("busy", busy_a, c <= 33);
      if (c <= 33) chk("pass_while_busy", pass_a, 0);
    end
    chk("err_count", err_a, stk ? 4 : 0);
    chk("pass", pass_a, !stk);
    if (stk) chk("first_fail", ff_a, 1);
    // Results hold in IDLE.
    repeat (3) @(negedge clk);
    chk("hold_err", err_a, stk ? 4 : 0);
    chk("hold_pass", pass_a, !stk);
    chk("hold_stim", stim_a, gray ? 4 : 7);
  endtask

  task automatic run_b(input logic [1:0] tbl, input int exp_err);
    exp_b = tbl;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("b_stim0", stim_b, 0);
    chk("b_done1", done_b, 0);
    @(negedge clk);
    chk("b_stim1", stim_b, 1);
    chk("b_done2", done_b, 0);
    @(negedge clk);
    chk("b_done3", done_b, 1);
    chk("b_busy3", busy_b, 1);
    @(negedge clk);
    chk("b_done4", done_b, 0);
    chk("b_busy4", busy_b, 0);
    chk("b_err", err_b, exp_err);
    chk("b_pass", pass_b, exp_err == 0);
    if (exp_err != 0) chk("b_first_fail", ff_b, 0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; mode_a = 1'b0; stuck = 1'b0;
    exp_a = 8'b1001_0110; start_b = 1'b0; exp_b = 2'b10;
    @(negedge clk);
    chk("rst_stim", stim_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ff", ff_a, 0);
    @(negedge clk); rst = 1'b0;

    run_a(1'b0, 1'b0, 1'b0);   // binary, XOR3 model
    run_a(1'b0, 1'b1, 1'b0);   // stuck-at-0 DUT
    run_a(1'b1, 1'b0, 1'b0);   // Gray order

    // Reset in mid-sweep while vector 5 is driven.
    @(negedge clk); mode_a = 1'b0; stuck = 1'b1; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (21) @(negedge clk);
    chk("mid_stim", stim_a, 5);
    chk("mid_err", err_a, 3);
    #2 rst = 1'b1;
    #1;
    chk("mrst_stim", stim_a, 0);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_done", done_a, 0);
    chk("mrst_pass", pass_a, 0);
    chk("mrst_err", err_a, 0);
    chk("mrst_ff", ff_a, 0);
    @(negedge clk); rst = 1'b0;
    run_a(1'b0, 1'b0, 1'b0);

    run_a(1'b0, 1'b0, 1'b1);   // start/mode pulses during sweep

    run_b(2'b10, 0);           // DWELL=1, WIDTH=1, matching
    run_b(2'b01, 2);           // every vector mismatches: err at max

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
